// File: rtl/cachepkg.sv
// rtl/cachepkg.sv - shared types for the two-requester cache arbiter
package cachepkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/arb_rr.sv
// rtl/arb_rr.sv - two-way round-robin pick: contention goes to the requester not granted last
module arb_rr
  import cachepkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_grant,
  output logic       valid,
  output req_idx_t   winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) winner = ~last_grant;
    else if (req[1])  winner = 1'b1;
  end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - L1I/L1D arbiter to next level; CACHE_ARB_TIMEOUT_EN adds a BUSY timeout with err
module cache_arbiter
  import cachepkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        wr,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rdata,
  output logic              mreq,
  output logic              mwr,
  output logic [ADDR_W-1:0] maddr,
  output logic [DATA_W-1:0] mwdata,
  input  logic              mack,
  input  logic [DATA_W-1:0] mrdata
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 16-bit counter");
  end

  arb_state_t state;
  req_idx_t   winner;
  req_idx_t   last_grant;
  logic       arb_valid;
  req_idx_t   arb_winner;

  arb_rr u_arb_rr (
    .req        (req),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt;
  logic [1:0]       err_q;
  assign err = err_q;
`else
  assign err = 2'b00;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      winner     <= 1'b0;
      last_grant <= 1'b1;
      mreq       <= 1'b0;
      mwr        <= 1'b0;
      maddr      <= '0;
      mwdata     <= '0;
      ack        <= 2'b00;
      rdata      <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt        <= '0;
      err_q      <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            winner     <= arb_winner;
            last_grant <= arb_winner;
            mreq       <= 1'b1;
            mwr        <= wr[arb_winner];
            maddr      <= arb_winner ? addr1 : addr0;
            mwdata     <= arb_winner ? wdata1 : wdata0;
            state      <= BUSY;
`ifdef CACHE_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
          end
        end
        BUSY: begin
          if (mack) begin
            mreq  <= 1'b0;
            mwr   <= 1'b0;
            maddr <= '0;
            mwdata <= '0;
            ack   <= winner ? 2'b10 : 2'b01;
            rdata <= mwr ? '0 : mrdata;
            state <= RESP;
`ifdef CACHE_ARB_TIMEOUT_EN
          end else if (cnt == CNT_LAST) begin
            // Give up on the next level: report completion with err and no data.
            mreq   <= 1'b0;
            mwr    <= 1'b0;
            maddr  <= '0;
            mwdata <= '0;
            ack    <= winner ? 2'b10 : 2'b01;
            err_q  <= winner ? 2'b10 : 2'b01;
            rdata  <= '0;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          ack   <= 2'b00;
          rdata <= '0;
          state <= IDLE;
`ifdef CACHE_ARB_TIMEOUT_EN
          err_q <= 2'b00;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
